chain_arbiter: RTL and testbench
================================

CHAIN_ARBITER -- requirements
Module: chain_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 2: cycles from chain_in update to valid chain_out sample; legal range 1..8.
REQ-002 SHALL have ports:
- clk  input  1  sole clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has data.
- req0_data  input  8  requester 0 operand.
- req0_ready  output  1  requester 0 accepted this cycle.
- req1_valid, req1_data, req1_ready  same as requester 0, for requester 1.
- flush  input  1  stop accepting and drain the pipeline.
- chain_in  output  8  registered operand to the shared chain datapath.
- chain_out  input  8  chain datapath result.
- rsp0_valid, rsp1_valid  output  1 each  result for requester 0 / 1.
- rsp_data  output  8  result data, shared by both requesters.
- busy  output  1  state not IDLE or any operand in flight.
- drain_done  output  1  one-cycle pulse when a flush completes.
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 Handshake: a transfer occurs in a cycle where reqN_valid and reqN_ready are both high; reqN_ready SHALL be combinational and never high for both requesters in the same cycle.
REQ-005 reqN_ready SHALL be 0 whenever flush=1 or state=DRAIN, regardless of valid.
REQ-006 Round-robin: with one valid requester, grant it; with both valid, grant the one not granted last. The last-grant pointer resets to 1, so req0 wins the first tie.
REQ-007 On acceptance in cycle T, chain_in SHALL take reqN_data at the end of cycle T; otherwise chain_in holds its value.
REQ-008 Tracking: a (valid, id) shift register LATENCY+1 deep SHALL track in-flight operands, with at most one issue per cycle. Back-to-back accepts SHALL sustain 1 result per cycle.
REQ-009 Response timing: rsp_data SHALL register chain_out at the end of cycle T+LATENCY. The matching rspN_valid SHALL be high for exactly cycle T+LATENCY+1, and the other rsp valid SHALL be 0 in that cycle.
REQ-010 Responses have no backpressure; rsp_data holds its last value when no rsp valid is high.
REQ-011 FSM states are IDLE, RUN and DRAIN:
- IDLE->RUN on any accept.
- RUN->IDLE when the pipeline is empty and no accept occurs this cycle.
- IDLE/RUN->DRAIN when flush=1 (flush has priority over a simultaneous request).
- DRAIN->IDLE in the first cycle the pipeline is empty; drain_done=1 in that cycle only.
REQ-012 Flush asserted with an empty pipeline SHALL enter DRAIN for one cycle and then pulse drain_done. flush held high after drain_done SHALL re-enter DRAIN.
REQ-013 In-flight operands SHALL complete and respond normally during DRAIN.
REQ-014 busy SHALL be 1 when state!=IDLE or any tracking-stage valid bit is set.

Reset
REQ-015 On rst_n=0 the block SHALL asynchronously set:
- chain_in=0, rsp_data=0, rsp0_valid=0, rsp1_valid=0.
- drain_done=0, busy=0.
- state=IDLE, last-grant pointer=1, all tracking stages invalid.
REQ-016 Reset mid-operation SHALL discard all in-flight operands; no response SHALL be emitted for them after reset release.
REQ-017 req0_ready and req1_ready may follow the valids combinationally from the first cycle after rst_n deasserts.

Configuration
REQ-018 With CHAIN_ARB_STATS_EN defined, the block SHALL add outputs grant0_cnt[15:0] and grant1_cnt[15:0]:
- each increments on its requester's accept;
- each saturates at 0xFFFF;
- each resets to 0.
Without the macro these ports and their counters SHALL NOT exist, and all other behaviour is identical.

Verification
REQ-019 LATENCY=2, req0 sends 0x11 at cycle 5 -> chain_in=0x11 from cycle 6; rsp0_valid=1 at cycle 8 only, with rsp_data equal to chain_out sampled at cycle 7.
REQ-020 Both requesters valid continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; rsp valids alternate with one result per cycle.
REQ-021 Three back-to-back accepts, then flush=1 on the next cycle -> readys 0, busy=1, three responses delivered, drain_done pulses once, then state=IDLE and busy=0.
REQ-022 flush and req1_valid asserted in the same cycle -> req1_ready=0 and no operand issued.
REQ-023 rst_n pulsed low with two operands in flight -> all outputs 0 immediately; no rsp valid after release.
REQ-024 With CHAIN_ARB_STATS_EN, force grant0_cnt to 0xFFFE and accept 3 req0 operands -> grant0_cnt=0xFFFF.

Source files
------------

// File: rtl/chain_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency chain datapath.
// Optional grant counters are enabled by defining CHAIN_ARB_STATS_EN.
module chain_arbiter #(
   parameter int LATENCY = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   input  logic       flush,
   output logic [7:0] chain_in,
   input  logic [7:0] chain_out,
   output logic       rsp0_valid,
   output logic       rsp1_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       drain_done
`ifdef CHAIN_ARB_STATS_EN
   ,
   output logic [15:0] grant0_cnt,
   output logic [15:0] grant1_cnt
`endif
);

   // state | meaning
   // IDLE  | nothing issued recently, waiting for a request
   // RUN   | accepting requests, operands may be in flight
   // DRAIN | no new accepts, waiting for the in-flight operands to retire
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t       state, state_nxt;
   logic         last_grant;
   logic         acc0, acc1, accept, empty;
   logic [LATENCY:0] trk_v;
   logic [LATENCY:0] trk_id;

   always_comb begin
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (!flush && state != DRAIN) begin
         if (req0_valid && req1_valid) begin
            if (last_grant) acc0 = 1'b1;
            else            acc1 = 1'b1;
         end else begin
            acc0 = req0_valid;
            acc1 = req1_valid;
         end
      end
   end

   assign req0_ready = acc0;
   assign req1_ready = acc1;
   assign accept     = acc0 | acc1;
   assign empty      = ~|trk_v;
   assign busy       = (state != IDLE) || !empty;
   assign rsp0_valid = trk_v[LATENCY] & ~trk_id[LATENCY];
   assign rsp1_valid = trk_v[LATENCY] &  trk_id[LATENCY];

   always_comb begin
      state_nxt  = state;
      drain_done = 1'b0;
      case (state)
         IDLE: begin
            if (flush)       state_nxt = DRAIN;
            else if (accept) state_nxt = RUN;
         end
         RUN: begin
            if (flush)                 state_nxt = DRAIN;
            else if (empty && !accept) state_nxt = IDLE;
         end
         DRAIN: begin
            if (empty) begin
               state_nxt  = IDLE;
               drain_done = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Stage k is valid in the (k+1)th cycle after the accept; the last stage is the response cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trk_v      <= '0;
         trk_id     <= '0;
         last_grant <= 1'b1;
         chain_in   <= 8'h00;
         rsp_data   <= 8'h00;
      end else begin
         trk_v  <= {trk_v[LATENCY-1:0], accept};
         trk_id <= {trk_id[LATENCY-1:0], acc1};
         if (accept) begin
            last_grant <= acc1;
            chain_in   <= acc1 ? req1_data : req0_data;
         end
         if (trk_v[LATENCY-1]) rsp_data <= chain_out;
      end
   end

`ifdef CHAIN_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant0_cnt <= 16'h0000;
         grant1_cnt <= 16'h0000;
      end else begin
         if (acc0 && grant0_cnt != 16'hFFFF) grant0_cnt <= grant0_cnt + 16'h0001;
         if (acc1 && grant1_cnt != 16'hFFFF) grant1_cnt <= grant1_cnt + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_chain_arbiter.sv
// Directed bench for chain_arbiter; the chain datapath is modelled as one register plus an XOR.
module tb_chain_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       flush;
   logic [7:0] chain_in;
   logic [7:0] chain_out;
   logic [7:0] chain_d1;
   logic       rsp0_valid, rsp1_valid;
   logic [7:0] rsp_data;
   logic       busy, drain_done;
`ifdef CHAIN_ARB_STATS_EN
   logic [15:0] grant0_cnt, grant1_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   chain_arbiter #(.LATENCY(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .flush      (flush),
      .chain_in   (chain_in),
      .chain_out  (chain_out),
      .rsp0_valid (rsp0_valid),
      .rsp1_valid (rsp1_valid),
      .rsp_data   (rsp_data),
      .busy       (busy),
      .drain_done (drain_done)
`ifdef CHAIN_ARB_STATS_EN
      ,
      .grant0_cnt (grant0_cnt),
      .grant1_cnt (grant1_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Chain result for an operand issued in cycle T is on chain_out in cycle T+2.
   always @(posedge clk) chain_d1 <= chain_in;
   assign chain_out = chain_d1 ^ 8'h5A;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_data = 8'h00; req1_data = 8'h00;
      chain_d1 = 8'h00;

      mid();
      check("rst_chain_in", chain_in, 8'h00);
      check("rst_rsp_data", rsp_data, 8'h00);
      check("rst_rsp0", rsp0_valid, 1'b0);
      check("rst_rsp1", rsp1_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_drain_done", drain_done, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      // single req0 operand, latency 2
      req0_valid = 1'b1; req0_data = 8'h11;
      mid();
      check("a_ready0", req0_ready, 1'b1);
      check("a_ready1", req1_ready, 1'b0);
      tick();
      req0_valid = 1'b0;
      mid();
      check("a_chain_in", chain_in, 8'h11);
      check("a_busy", busy, 1'b1);
      check("a_rsp0_early1", rsp0_valid, 1'b0);
      tick();
      mid();
      check("a_rsp0_early2", rsp0_valid, 1'b0);
      tick();
      mid();
      check("a_rsp0", rsp0_valid, 1'b1);
      check("a_rsp1", rsp1_valid, 1'b0);
      check("a_rsp_data", rsp_data, 8'h4B);
      tick();
      mid();
      check("a_rsp0_after", rsp0_valid, 1'b0);
      check("a_rsp_data_hold", rsp_data, 8'h4B);
      check("a_busy_tail", busy, 1'b1);
      tick();
      mid();
      check("a_busy_idle", busy, 1'b0);
      tick();

      rst_n = 1'b0;
      mid();
      tick();
      rst_n = 1'b1;

      // both requesters valid: alternate 0,1,0,1,0,1
      for (int i = 0; i < 10; i++) begin
         req0_valid = (i < 6);
         req1_valid = (i < 6);
         req0_data  = 8'h20 + 8'(i);
         req1_data  = 8'h30 + 8'(i);
         mid();
         if (i < 6) begin
            check($sformatf("b_ready0_%0d", i), req0_ready, ((i % 2) == 0) ? 1'b1 : 1'b0);
            check($sformatf("b_ready1_%0d", i), req1_ready, ((i % 2) == 1) ? 1'b1 : 1'b0);
         end
         if (i >= 3 && i < 9) begin
            check($sformatf("b_rsp0_%0d", i), rsp0_valid, (((i - 3) % 2) == 0) ? 1'b1 : 1'b0);
            check($sformatf("b_rsp1_%0d", i), rsp1_valid, (((i - 3) % 2) == 1) ? 1'b1 : 1'b0);
            check($sformatf("b_rsp_data_%0d", i), rsp_data,
                  (((i - 3) % 2) == 0 ? 8'h20 + 8'(i - 3) : 8'h30 + 8'(i - 3)) ^ 8'h5A);
         end else begin
            check($sformatf("b_rsp_none_%0d", i), rsp0_valid | rsp1_valid, 1'b0);
         end
         tick();
      end
      repeat (2) tick();

      // three back-to-back accepts then flush
      req0_valid = 1'b1; req0_data = 8'h41;
      mid(); check("c_ready0_0", req0_ready, 1'b1); tick();
      req0_data = 8'h42;
      mid(); check("c_ready0_1", req0_ready, 1'b1); tick();
      req0_data = 8'h43;
      mid(); check("c_ready0_2", req0_ready, 1'b1); tick();
      req0_data = 8'h44; flush = 1'b1;
      mid();
      check("c3_ready0", req0_ready, 1'b0);
      check("c3_busy", busy, 1'b1);
      check("c3_rsp0", rsp0_valid, 1'b1);
      check("c3_rsp_data", rsp_data, 8'h1B);
      check("c3_drain_done", drain_done, 1'b0);
      tick();
      flush = 1'b0;
      mid();
      check("c4_ready0", req0_ready, 1'b0);
      check("c4_chain_in", chain_in, 8'h43);
      check("c4_rsp0", rsp0_valid, 1'b1);
      check("c4_rsp_data", rsp_data, 8'h18);
      check("c4_drain_done", drain_done, 1'b0);
      tick();
      mid();
      check("c5_ready0", req0_ready, 1'b0);
      check("c5_rsp0", rsp0_valid, 1'b1);
      check("c5_rsp_data", rsp_data, 8'h19);
      check("c5_drain_done", drain_done, 1'b0);
      tick();
      mid();
      check("c6_ready0", req0_ready, 1'b0);
      check("c6_rsp0", rsp0_valid, 1'b0);
      check("c6_drain_done", drain_done, 1'b1);
      check("c6_busy", busy, 1'b1);
      tick();
      req0_valid = 1'b0;
      mid();
      check("c7_drain_done", drain_done, 1'b0);
      check("c7_busy", busy, 1'b0);
      tick();

      // flush with a simultaneous request on an empty pipeline
      flush = 1'b1; req1_valid = 1'b1; req1_data = 8'h77;
      mid();
      check("d0_ready1", req1_ready, 1'b0);
      check("d0_ready0", req0_ready, 1'b0);
      tick();
      flush = 1'b0; req1_valid = 1'b0;
      mid();
      check("d1_drain_done", drain_done, 1'b1);
      check("d1_busy", busy, 1'b1);
      tick();
      mid();
      check("d2_drain_done", drain_done, 1'b0);
      check("d2_busy", busy, 1'b0);
      check("d2_chain_in", chain_in, 8'h43);
      tick();
      mid();
      check("d3_rsp1", rsp1_valid, 1'b0);
      tick();

      // flush held high re-enters DRAIN after drain_done
      flush = 1'b1;
      mid(); check("f0_drain_done", drain_done, 1'b0); tick();
      mid(); check("f1_drain_done", drain_done, 1'b1); tick();
      mid(); check("f2_drain_done", drain_done, 1'b0); check("f2_busy", busy, 1'b0); tick();
      mid(); check("f3_drain_done", drain_done, 1'b1); tick();
      flush = 1'b0;
      mid(); check("f4_busy", busy, 1'b0); tick();

      // lone req1, then a tie that req0 must win
      req1_valid = 1'b1; req1_data = 8'h9C;
      mid(); check("e0_ready1", req1_ready, 1'b1); tick();
      req0_valid = 1'b1; req0_data = 8'h3A; req1_data = 8'h3B;
      mid();
      check("e1_ready0", req0_ready, 1'b1);
      check("e1_ready1", req1_ready, 1'b0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      mid(); tick();
      mid();
      check("e3_rsp1", rsp1_valid, 1'b1);
      check("e3_rsp0", rsp0_valid, 1'b0);
      check("e3_rsp_data", rsp_data, 8'hC6);
      tick();
      mid();
      check("e4_rsp0", rsp0_valid, 1'b1);
      check("e4_rsp1", rsp1_valid, 1'b0);
      check("e4_rsp_data", rsp_data, 8'h60);
      tick();
      repeat (2) tick();

      // reset with two operands in flight
      req0_valid = 1'b1; req0_data = 8'h55;
      mid(); check("g0_ready0", req0_ready, 1'b1); tick();
      req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 8'h66;
      mid(); check("g1_ready1", req1_ready, 1'b1); tick();
      req1_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("g_rst_chain_in", chain_in, 8'h00);
      check("g_rst_rsp_data", rsp_data, 8'h00);
      check("g_rst_busy", busy, 1'b0);
      check("g_rst_rsp", rsp0_valid | rsp1_valid, 1'b0);
      check("g_rst_drain_done", drain_done, 1'b0);
      mid();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         mid();
         check($sformatf("g_post_rsp_%0d", k), rsp0_valid | rsp1_valid, 1'b0);
         check($sformatf("g_post_busy_%0d", k), busy, 1'b0);
         tick();
      end
      req0_valid = 1'b1; req0_data = 8'h01;
      mid(); check("g_post_ready0", req0_ready, 1'b1); tick();
      req0_valid = 1'b0;

`ifdef CHAIN_ARB_STATS_EN
      rst_n = 1'b0;
      #1;
      check("s_rst_cnt0", grant0_cnt, 16'h0000);
      tick();
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_data = 8'h02;
      repeat (65537) tick();
      req0_valid = 1'b0;
      mid();
      check("s_cnt0_sat", grant0_cnt, 16'hFFFF);
      check("s_cnt1", grant1_cnt, 16'h0000);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
